// File: rtl/mm_addr_router.sv
// Memory-mapped address router: one registered request stage, posted writes, single outstanding read.
// Optional read timeout enabled by defining MM_ADDR_ROUTER_TIMEOUT_EN.
module mm_addr_router #(
  parameter int NUM_SLV     = 8,
  parameter int ADDR_W      = 14,
  parameter int SEL_W       = 4,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    iMM_WR_EN,
  input  logic                    iMM_RD_EN,
  input  logic [ADDR_W-1:0]       iMM_ADDR,
  input  logic [63:0]             iMM_WR_DATA,
  output logic [63:0]             oMM_RD_DATA,
  output logic                    oMM_RD_DATA_V,
  output logic                    oBUSY,
  output logic                    oRD_DROP,
  output logic                    oRD_TIMEOUT,
  output logic [15:0]             oTIMEOUT_CNT,
  output logic [ADDR_W-1:0]       SLV_ADDR,
  output logic [63:0]             SLV_WR_DATA,
  output logic [NUM_SLV-1:0]      SLV_WR_EN,
  output logic [NUM_SLV-1:0]      SLV_RD_EN,
  input  logic [NUM_SLV*64-1:0]   SLV_RD_DATA,
  input  logic [NUM_SLV-1:0]      SLV_RD_DATA_V,
  output logic [1:0]              o_dbg_state
);

  // Handshake: a request is a single-cycle strobe (no ready); responses are
  // single-cycle oMM_RD_DATA_V pulses; slaves answer with one SLV_RD_DATA_V pulse.

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  if (NUM_SLV < 1 || NUM_SLV > 16 || SEL_W >= ADDR_W || ADDR_W > 32 ||
      TIMEOUT_CYC < 1 || TIMEOUT_CYC > 65535) begin : g_bad_param
    $error("mm_addr_router: parameter out of range");
  end

  state_t              r_state;
  logic [ADDR_W-1:0]   r_laddr;
  logic                r_lwen;
  logic                r_lren;
  logic [63:0]         r_lwdata;
  logic [SEL_W-1:0]    r_sel;
  logic [63:0]         r_rd_data;
  logic                r_rd_data_v;
  logic                r_rd_drop;
  logic [SEL_W-1:0]    w_idx;
  logic                w_hit;
  logic [NUM_SLV-1:0]  w_idx_oh;
  logic [63:0]         w_sel_data;
  logic                w_sel_v;
  logic [63:0]         w_miss_data;

  assign w_idx       = r_laddr[ADDR_W-1 -: SEL_W];
  assign w_hit       = ({{(32-SEL_W){1'b0}}, w_idx} < NUM_SLV);
  assign w_miss_data = {32'h5555_AAAA, 32'(r_laddr)};

  always_comb begin
    w_idx_oh   = '0;
    w_sel_data = '0;
    w_sel_v    = 1'b0;
    for (int i = 0; i < NUM_SLV; i++) begin
      w_idx_oh[i] = (w_idx == SEL_W'(i));
      if (r_sel == SEL_W'(i)) begin
        w_sel_data = SLV_RD_DATA[64*i +: 64];
        w_sel_v    = SLV_RD_DATA_V[i];
      end
    end
  end

  // Request stage feeds the shared slave bus directly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_laddr  <= '0;
      r_lwen   <= 1'b0;
      r_lren   <= 1'b0;
      r_lwdata <= '0;
    end else begin
      r_laddr  <= iMM_ADDR;
      r_lwen   <= iMM_WR_EN;
      r_lren   <= iMM_RD_EN;
      r_lwdata <= iMM_WR_DATA;
    end
  end

  assign SLV_ADDR    = r_laddr;
  assign SLV_WR_DATA = r_lwdata;
  assign SLV_WR_EN   = (r_lwen && w_hit) ? w_idx_oh : '0;
  assign SLV_RD_EN   = (r_lren && w_hit && r_state == S_IDLE) ? w_idx_oh : '0;

`ifdef MM_ADDR_ROUTER_TIMEOUT_EN
  logic [15:0]       r_wait_cnt;
  logic [15:0]       r_timeout_cnt;
  logic              r_rd_timeout;
  logic [ADDR_W-1:0] r_req_addr;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_sel       <= '0;
      r_rd_data   <= '0;
      r_rd_data_v <= 1'b0;
      r_rd_drop   <= 1'b0;
`ifdef MM_ADDR_ROUTER_TIMEOUT_EN
      r_wait_cnt    <= '0;
      r_timeout_cnt <= '0;
      r_rd_timeout  <= 1'b0;
      r_req_addr    <= '0;
`endif
    end else begin
      r_rd_data_v <= 1'b0;
      r_rd_drop   <= r_lren && (r_state != S_IDLE);
`ifdef MM_ADDR_ROUTER_TIMEOUT_EN
      r_rd_timeout <= 1'b0;
`endif
      case (r_state)
        S_IDLE: begin
          if (r_lren && w_hit) begin
            r_sel   <= w_idx;
            r_state <= S_WAIT;
`ifdef MM_ADDR_ROUTER_TIMEOUT_EN
            r_wait_cnt <= '0;
            r_req_addr <= r_laddr;
`endif
          end else if (r_lren) begin
            r_rd_data   <= w_miss_data;
            r_rd_data_v <= 1'b1;
            r_state     <= S_RESP;
          end
        end
        S_WAIT: begin
          // A valid arriving on the timeout cycle still wins.
          if (w_sel_v) begin
            r_rd_data   <= w_sel_data;
            r_rd_data_v <= 1'b1;
            r_state     <= S_RESP;
          end
`ifdef MM_ADDR_ROUTER_TIMEOUT_EN
          else if (r_wait_cnt == 16'(TIMEOUT_CYC - 1)) begin
            r_rd_data     <= {32'hDEAD_BEEF, 32'(r_req_addr)};
            r_rd_data_v   <= 1'b1;
            r_rd_timeout  <= 1'b1;
            r_state       <= S_RESP;
            if (r_timeout_cnt != 16'hFFFF) r_timeout_cnt <= r_timeout_cnt + 16'd1;
          end else begin
            r_wait_cnt <= r_wait_cnt + 16'd1;
          end
`endif
        end
        S_RESP:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef MM_ADDR_ROUTER_TIMEOUT_EN
  assign oRD_TIMEOUT  = r_rd_timeout;
  assign oTIMEOUT_CNT = r_timeout_cnt;
`else
  assign oRD_TIMEOUT  = 1'b0;
  assign oTIMEOUT_CNT = 16'd0;
`endif

  assign oMM_RD_DATA   = r_rd_data;
  assign oMM_RD_DATA_V = r_rd_data_v;
  assign oRD_DROP      = r_rd_drop;
  assign oBUSY         = (r_state != S_IDLE);
  assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_mm_addr_router.sv
// Bench for mm_addr_router: directed cases plus random reads/writes against a rule-level model.
module tb_mm_addr_router;

  localparam int NUM_SLV = 8;
  localparam int ADDR_W  = 14;
  localparam int SEL_W   = 4;
  localparam int TO      = 4;
`ifdef MM_ADDR_ROUTER_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  iMM_WR_EN = 1'b0;
  logic                  iMM_RD_EN = 1'b0;
  logic [ADDR_W-1:0]     iMM_ADDR = '0;
  logic [63:0]           iMM_WR_DATA = '0;
  logic [63:0]           oMM_RD_DATA;
  logic                  oMM_RD_DATA_V;
  logic                  oBUSY;
  logic                  oRD_DROP;
  logic                  oRD_TIMEOUT;
  logic [15:0]           oTIMEOUT_CNT;
  logic [ADDR_W-1:0]     SLV_ADDR;
  logic [63:0]           SLV_WR_DATA;
  logic [NUM_SLV-1:0]    SLV_WR_EN;
  logic [NUM_SLV-1:0]    SLV_RD_EN;
  logic [NUM_SLV*64-1:0] SLV_RD_DATA = '0;
  logic [NUM_SLV-1:0]    SLV_RD_DATA_V = '0;
  logic [1:0]            o_dbg_state;

  mm_addr_router #(.NUM_SLV(NUM_SLV), .ADDR_W(ADDR_W), .SEL_W(SEL_W), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .iMM_WR_EN(iMM_WR_EN), .iMM_RD_EN(iMM_RD_EN), .iMM_ADDR(iMM_ADDR), .iMM_WR_DATA(iMM_WR_DATA),
    .oMM_RD_DATA(oMM_RD_DATA), .oMM_RD_DATA_V(oMM_RD_DATA_V), .oBUSY(oBUSY),
    .oRD_DROP(oRD_DROP), .oRD_TIMEOUT(oRD_TIMEOUT), .oTIMEOUT_CNT(oTIMEOUT_CNT),
    .SLV_ADDR(SLV_ADDR), .SLV_WR_DATA(SLV_WR_DATA), .SLV_WR_EN(SLV_WR_EN), .SLV_RD_EN(SLV_RD_EN),
    .SLV_RD_DATA(SLV_RD_DATA), .SLV_RD_DATA_V(SLV_RD_DATA_V), .o_dbg_state(o_dbg_state)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Scoreboard state
  int checks = 0;
  int errors = 0;
  logic [64:0]                    exp_q[$];   // {timeout_flag, data}
  logic [NUM_SLV+ADDR_W+64-1:0]   wr_q[$];    // {mask, addr, data}
  logic [15:0]                    exp_to_cnt = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int model_idx(input logic [ADDR_W-1:0] a);
    return int'(a) / (1 << (ADDR_W - SEL_W));
  endfunction

  function automatic bit model_hit(input logic [ADDR_W-1:0] a);
    return model_idx(a) < NUM_SLV;
  endfunction

  task automatic push_write(input logic [ADDR_W-1:0] a, input logic [63:0] d);
    logic [NUM_SLV-1:0] m;
    if (model_hit(a)) begin
      m = '0;
      m[model_idx(a)] = 1'b1;
      wr_q.push_back({m, a, d});
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents a response or write
  initial begin
    logic [64:0] e;
    logic [NUM_SLV+ADDR_W+64-1:0] w;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (oMM_RD_DATA_V) begin
          if (exp_q.size() == 0) chk("unexpected_rsp", 64'(oMM_RD_DATA_V), 64'd0);
          else begin
            e = exp_q.pop_front();
            chk("rd_data", oMM_RD_DATA, e[63:0]);
            chk("rd_timeout_pulse", 64'(oRD_TIMEOUT), 64'(e[64]));
          end
        end else if (oRD_TIMEOUT) begin
          chk("stray_timeout", 64'(oRD_TIMEOUT), 64'd0);
        end
        if (|SLV_WR_EN) begin
          if (wr_q.size() == 0) chk("unexpected_wr", 64'(SLV_WR_EN), 64'd0);
          else begin
            w = wr_q.pop_front();
            chk("wr_en", 64'(SLV_WR_EN), 64'(w[NUM_SLV+ADDR_W+63 -: NUM_SLV]));
            chk("wr_addr", 64'(SLV_ADDR), 64'(w[ADDR_W+63 -: ADDR_W]));
            chk("wr_data", SLV_WR_DATA, w[63:0]);
          end
        end
      end
    end
  end

  // Driver tasks
  task automatic do_write(input logic [ADDR_W-1:0] a, input logic [63:0] d);
    @(negedge clk);
    iMM_ADDR = a; iMM_WR_DATA = d; iMM_WR_EN = 1'b1;
    push_write(a, d);
    @(negedge clk);
    iMM_WR_EN = 1'b0;
  endtask

  task automatic do_read(input logic [ADDR_W-1:0] a, input int d, input bit with_wr,
                         input bit drop_test, input logic [63:0] sdata);
    int idx = model_idx(a);
    bit hit = model_hit(a);
    bit tmo = TO_EN && hit && (d > TO);
    logic [NUM_SLV-1:0] smask = '0;
    logic [NUM_SLV-1:0] noise;
    logic [63:0] exp_d;
    logic [63:0] wd;
    int lat = 0, busy_n = 0, rden_n = 0, drop_n = 0, exp_busy;
    for (int i = 0; i < NUM_SLV; i++) SLV_RD_DATA[64*i +: 64] = {$urandom, $urandom};
    if (hit) begin
      smask[idx] = 1'b1;
      SLV_RD_DATA[64*idx +: 64] = sdata;
    end
    if (!hit)     exp_d = {32'h5555_AAAA, 32'(a)};
    else if (tmo) exp_d = {32'hDEAD_BEEF, 32'(a)};
    else          exp_d = sdata;
    exp_q.push_back({tmo, exp_d});
    if (tmo && exp_to_cnt != 16'hFFFF) exp_to_cnt = exp_to_cnt + 16'd1;
    exp_busy = !hit ? 1 : (tmo ? TO + 1 : d + 1);

    @(negedge clk);
    iMM_ADDR = a; iMM_RD_EN = 1'b1;
    if (with_wr) begin
      wd = {$urandom, $urandom};
      iMM_WR_DATA = wd; iMM_WR_EN = 1'b1;
      push_write(a, wd);
    end
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (|SLV_RD_EN) begin
        rden_n++;
        chk("rd_en_mask", 64'(SLV_RD_EN), (k == 1) ? 64'(smask) : 64'd0);
      end
      if (oBUSY) busy_n++;
      if (oRD_DROP) drop_n++;
      if (oMM_RD_DATA_V && lat == 0) lat = k;
      iMM_RD_EN = 1'b0; iMM_WR_EN = 1'b0;
      if (drop_test && k == 2) begin
        iMM_ADDR = 14'($urandom);
        wd = {$urandom, $urandom};
        iMM_WR_DATA = wd; iMM_RD_EN = 1'b1; iMM_WR_EN = 1'b1;
        push_write(iMM_ADDR, wd);
      end
      noise = NUM_SLV'($urandom) & ~smask;
      SLV_RD_DATA_V = noise;
      if (hit && !tmo && k == d + 1) SLV_RD_DATA_V = noise | smask;
      if (lat != 0 && !oBUSY && k >= 2) break;
    end
    SLV_RD_DATA_V = '0;
    chk("rd_latency", 64'(lat), 64'(exp_busy + 1));
    chk("busy_cycles", 64'(busy_n), 64'(exp_busy));
    chk("rd_en_count", 64'(rden_n), 64'(hit));
    chk("drop_count", 64'(drop_n), 64'(drop_test));
    chk("timeout_cnt", 64'(oTIMEOUT_CNT), 64'(exp_to_cnt));
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_rd_data"}, oMM_RD_DATA, 64'd0);
    chk({tag, "_rd_v"}, 64'(oMM_RD_DATA_V), 64'd0);
    chk({tag, "_busy"}, 64'(oBUSY), 64'd0);
    chk({tag, "_drop"}, 64'(oRD_DROP), 64'd0);
    chk({tag, "_tmo"}, 64'(oRD_TIMEOUT), 64'd0);
    chk({tag, "_tmo_cnt"}, 64'(oTIMEOUT_CNT), 64'd0);
    chk({tag, "_wr_en"}, 64'(SLV_WR_EN), 64'd0);
    chk({tag, "_rd_en"}, 64'(SLV_RD_EN), 64'd0);
    chk({tag, "_state"}, 64'(o_dbg_state), 64'd0);
  endtask

  // Stimulus
  initial begin
    logic [ADDR_W-1:0] a;
    int rsp_seen;
    repeat (3) @(negedge clk);
    chk_idle_outputs("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    do_write(14'h0C05, 64'h1234);
    do_read(14'h1404, 3, 1'b0, 1'b0, 64'hCAFE);
    do_read(14'h2010, 1, 1'b0, 1'b0, 64'h0);
    do_read(14'h0805, TO + 1, 1'b0, 1'b0, 64'h1111_2222_3333_4444);
    do_read(14'h0805, TO, 1'b0, 1'b0, 64'h5555_6666_7777_8888);
    do_read(14'h1C3F, 2, 1'b0, 1'b1, 64'hABCD_0001);
    do_read(14'h0400, 1, 1'b1, 1'b0, 64'h0BAD_F00D);
    do_read(14'h3FFF, 2, 1'b1, 1'b0, 64'h0);

    // Reset in the middle of a wait, then a late slave answer
    @(negedge clk);
    iMM_ADDR = 14'h1800; iMM_RD_EN = 1'b1;
    @(negedge clk);
    iMM_RD_EN = 1'b0;
    chk("mid_rst_rd_en", 64'(SLV_RD_EN), 64'h40);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    exp_to_cnt = '0;
    chk_idle_outputs("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    SLV_RD_DATA_V = 8'h40;
    @(negedge clk);
    SLV_RD_DATA_V = '0;
    rsp_seen = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (oMM_RD_DATA_V) rsp_seen++;
    end
    chk("post_rst_no_rsp", 64'(rsp_seen), 64'd0);
    chk("post_rst_busy", 64'(oBUSY), 64'd0);
    chk("post_rst_state", 64'(o_dbg_state), 64'd0);

    for (int n = 0; n < 60; n++) begin
      a = ADDR_W'($urandom);
      if ($urandom_range(0, 2) == 0) do_write(ADDR_W'($urandom), {$urandom, $urandom});
      do_read(a, $urandom_range(1, 6), 1'($urandom_range(0, 1)),
              model_hit(a) && ($urandom_range(0, 3) == 0), {$urandom, $urandom});
    end

    repeat (4) @(negedge clk);
    chk("rsp_queue_empty", 64'(exp_q.size()), 64'd0);
    chk("wr_queue_empty", 64'(wr_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mm_addr_router.md
MM_ADDR_ROUTER -- requirements
Module: mm_addr_router

Interface
REQ-001 The block SHALL have parameter NUM_SLV, default 8, giving the number of slave ports (1..16).
REQ-002 The block SHALL have parameter ADDR_W, default 14, giving the MM address width.
REQ-003 The block SHALL have parameter SEL_W, default 4, giving the number of address MSBs used as slave index; SEL_W < ADDR_W.
REQ-004 The block SHALL have parameter TIMEOUT_CYC, default 255, giving the read-wait limit in clk cycles (1..65535).
REQ-005 The block SHALL use one clock and an asynchronous active-low reset, with ports as follows:
- clk  input  1  sole clock; all state on posedge.
- rst_n  input  1  asynchronous active-low reset.
- iMM_WR_EN  input  1  write strobe.
- iMM_RD_EN  input  1  read strobe.
- iMM_ADDR  input  ADDR_W  request address.
- iMM_WR_DATA  input  64  write data.
- oMM_RD_DATA  output  64  read response data.
- oMM_RD_DATA_V  output  1  one-cycle response-valid pulse.
- oBUSY  output  1  read outstanding.
- oRD_DROP  output  1  one-cycle pulse when a read is discarded.
- oRD_TIMEOUT  output  1  one-cycle pulse when a read times out.
- oTIMEOUT_CNT  output  16  saturating timeout count.
- SLV_ADDR  output  ADDR_W  shared slave address.
- SLV_WR_DATA  output  64  shared slave write data.
- SLV_WR_EN  output  NUM_SLV  per-slave write pulse.
- SLV_RD_EN  output  NUM_SLV  per-slave read pulse.
- SLV_RD_DATA  input  NUM_SLV*64  slave i data at bits [64*i+63:64*i].
- SLV_RD_DATA_V  input  NUM_SLV  per-slave response valid.

Function
REQ-006 The block SHALL register iMM_ADDR, iMM_WR_EN, iMM_RD_EN and iMM_WR_DATA into laddr, lwen, lren and lwdata (one stage); SLV_ADDR SHALL equal laddr and SLV_WR_DATA SHALL equal lwdata.
REQ-007 The slave index SHALL be idx = laddr[ADDR_W-1 -: SEL_W]; a request SHALL be a hit when idx < NUM_SLV and a miss otherwise.
REQ-008 Writes: SLV_WR_EN[idx] SHALL equal lwen & hit, combinationally from the registered stage, so it is asserted one cycle after iMM_WR_EN. Writes SHALL be posted and SHALL be forwarded in every FSM state.
REQ-009 The read FSM SHALL have states IDLE, WAIT and RESP.
REQ-010 In IDLE, a cycle with lren & hit SHALL pulse SLV_RD_EN[idx] that cycle, latch idx into sel, clear the wait counter and go to WAIT.
REQ-011 In IDLE, lren & miss SHALL load response {32'h5555_AAAA, zero-pad, laddr} and go to RESP, so oMM_RD_DATA_V is asserted 2 cycles after iMM_RD_EN.
REQ-012 In WAIT, SLV_RD_DATA_V[sel]=1 SHALL capture slave sel's data and go to RESP.
REQ-013 In WAIT, the wait counter SHALL increment each cycle. When the counter equals TIMEOUT_CYC-1 and no valid is present, the FSM SHALL load {32'hDEAD_BEEF, zero-pad, laddr_latched}, pulse oRD_TIMEOUT, increment oTIMEOUT_CNT (saturating at 16'hFFFF) and go to RESP.
REQ-014 If valid and timeout occur in the same cycle, valid SHALL win: data is captured and there is no oRD_TIMEOUT pulse.
REQ-015 RESP SHALL assert oMM_RD_DATA_V for exactly one cycle with the captured data and return to IDLE; oMM_RD_DATA SHALL hold its value until the next response.
REQ-016 oBUSY SHALL be 1 in WAIT and RESP.
REQ-017 lren in WAIT or RESP SHALL be discarded, with no SLV_RD_EN, and SHALL pulse oRD_DROP.
REQ-018 SLV_RD_DATA_V from a non-selected slave, or any SLV_RD_DATA_V while in IDLE, SHALL be ignored.
REQ-019 Simultaneous lwen and lren SHALL forward both: the write per REQ-008 and the read per the FSM.

Reset
REQ-020 On rst_n low, asynchronously:
- all registered stages SHALL clear to 0;
- the FSM SHALL go to IDLE;
- oMM_RD_DATA, oMM_RD_DATA_V, oBUSY, oRD_DROP, oRD_TIMEOUT, oTIMEOUT_CNT, SLV_WR_EN and SLV_RD_EN SHALL be 0.
REQ-021 Reset during WAIT SHALL abandon the outstanding read with no response; a late SLV_RD_DATA_V after reset SHALL be ignored per REQ-018.

Configuration
REQ-022 With macro MM_ADDR_ROUTER_TIMEOUT_EN defined, the timeout logic of REQ-013 and REQ-014 SHALL be present.
REQ-023 Without MM_ADDR_ROUTER_TIMEOUT_EN:
- WAIT SHALL persist until a valid response arrives;
- the wait counter SHALL be absent;
- oRD_TIMEOUT and oTIMEOUT_CNT SHALL be tied to 0.

Verification
REQ-024 Write hit: iMM_WR_EN, addr 14'h0C05, data 64'h1234 -> SLV_WR_EN=8'h08 one cycle later, SLV_ADDR=14'h0C05, SLV_WR_DATA=64'h1234.
REQ-025 Read hit: read addr 14'h1404 (idx 5); slave 5 returns 64'hCAFE 3 cycles after SLV_RD_EN[5] -> oMM_RD_DATA_V one cycle later with 64'hCAFE; oBUSY high for 4 cycles.
REQ-026 Read miss: read addr 14'h2010 (idx 8) -> oMM_RD_DATA=64'h5555_AAAA_0000_2010 2 cycles after iMM_RD_EN; no SLV_RD_EN.
REQ-027 Timeout (macro defined, TIMEOUT_CYC=4): read idx 2, slave silent -> oRD_TIMEOUT pulse and response 64'hDEAD_BEEF_0000_08xx after 4 WAIT cycles; oTIMEOUT_CNT=1. A second run with valid in the 4th WAIT cycle -> slave data returned, oTIMEOUT_CNT unchanged.
REQ-028 Read during WAIT -> oRD_DROP pulse and no second SLV_RD_EN; a write issued during WAIT is still forwarded.
REQ-029 rst_n asserted mid-WAIT, then slave valid after release -> no oMM_RD_DATA_V; FSM in IDLE.
